// File: rtl/mips_pkg.sv
// Shared field positions, reset default and fetch FSM state type for the fetch unit.
// No logic, so no latency.
// No handshakes of its own, so no backpressure behaviour.
package mips_pkg;

   localparam int OPC_W    = 6;
   localparam int FUNC_W   = 6;
   localparam int OPC_MSB  = 31;
   localparam int OPC_LSB  = OPC_MSB - OPC_W + 1;
   localparam int FUNC_LSB = 0;
   localparam int FUNC_MSB = FUNC_LSB + FUNC_W - 1;
   localparam int IMM_W    = 16;
   localparam int JIDX_W   = 26;

   localparam logic [31:0] RESET_PC_DFLT = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH_REQ,
      FETCH_WAIT,
      ISSUE,
      HALTED
   } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Selects the next PC (jump-register, jump, taken branch or sequential) and flags misaligned targets.
// Purely combinational, zero cycles.
// No handshakes; the result is consumed only when the current instruction retires.
module next_pc_calc
   import mips_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] inst,
   input  logic        jump,
   input  logic        jump_reg,
   input  logic        branch,
   input  logic        zero,
   input  logic [31:0] jr_target,
   output logic [31:0] next_pc,
   output logic        misaligned
);

   logic [31:0] pc_plus4;
   logic [31:0] jump_tgt;
   logic [31:0] br_off;
   logic        unused_opc;

   assign pc_plus4 = pc + 32'd4;
   // Jump keeps the 256 MB region of the sequential address.
   assign jump_tgt = {pc_plus4[31:28], inst[JIDX_W-1:0], 2'b00};
   // Branch offset is a sign-extended word offset.
   assign br_off   = {{(32-IMM_W-2){inst[IMM_W-1]}}, inst[IMM_W-1:0], 2'b00};
   // The opcode field plays no part in target selection.
   assign unused_opc = ^inst[OPC_MSB:OPC_LSB];

   // Priority select: jump-register, jump, taken branch, then sequential.
   always_comb begin
      next_pc = pc_plus4;
      if (jump && jump_reg) begin
         next_pc = jr_target;
      end else if (jump) begin
         next_pc = jump_tgt;
      end else if (branch && zero) begin
         next_pc = pc_plus4 + br_off;
      end
   end

   assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/instr_fetch.sv
// Multi-cycle fetch/issue unit: fetches a word, holds it for execution, then steps the PC.
// At least 3 cycles per instruction (request, ack, issue with exec_done).
// Waits indefinitely for imem_ack and for exec_done; halts stick until reset.
module instr_fetch
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DFLT,
   parameter int          CNT_W    = 32
)
(
   input  logic             clk,
   input  logic             rst_b,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_ack,
   input  logic [31:0]      imem_rdata,
   output logic [31:0]      inst,
   output logic [5:0]       opcode,
   output logic [5:0]       func,
   output logic             inst_valid,
   input  logic             exec_done,
   input  logic             jump,
   input  logic             jump_reg,
   input  logic             branch,
   input  logic             zero,
   input  logic [31:0]      jr_target,
   input  logic             halted_in,
   output logic [31:0]      pc,
   output logic [31:0]      pc_plus4,
   output logic             halt,
   output logic             fault,
   output logic [CNT_W-1:0] retired
);

   fetch_state_t state;
   fetch_state_t state_nxt;
   logic [31:0]  next_pc;
   logic         misaligned;
   logic         retire;

   next_pc_calc u_next_pc (
      .pc         (pc),
      .inst       (inst),
      .jump       (jump),
      .jump_reg   (jump_reg),
      .branch     (branch),
      .zero       (zero),
      .jr_target  (jr_target),
      .next_pc    (next_pc),
      .misaligned (misaligned)
   );

   // Request and valid come straight from the state, so reset clears them at once
   // and an ack outside FETCH_WAIT can never be taken.
   assign imem_req   = (state == FETCH_WAIT);
   assign inst_valid = (state == ISSUE);
   assign imem_addr  = pc;
   assign opcode     = inst[OPC_MSB:OPC_LSB];
   assign func       = inst[FUNC_MSB:FUNC_LSB];
   assign pc_plus4   = pc + 32'd4;
   assign retire     = (state == ISSUE) && exec_done;

   // State register.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state <= FETCH_REQ;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: a retiring instruction either stops the machine or starts the next fetch.
   always_comb begin
      state_nxt = state;
      case (state)
         FETCH_REQ:  state_nxt = FETCH_WAIT;
         FETCH_WAIT: if (imem_ack) state_nxt = ISSUE;
         ISSUE: begin
            if (exec_done) begin
               state_nxt = (halted_in || misaligned) ? HALTED : FETCH_REQ;
            end
         end
         HALTED:     state_nxt = HALTED;
         default:    state_nxt = FETCH_REQ;
      endcase
   end

   // Architectural state: instruction latch, PC step, sticky halt/fault, saturating retire count.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         pc      <= RESET_PC;
         inst    <= 32'h0;
         halt    <= 1'b0;
         fault   <= 1'b0;
         retired <= '0;
      end else begin
         if ((state == FETCH_WAIT) && imem_ack) begin
            inst <= imem_rdata;
         end
         if (retire) begin
            if (retired != {CNT_W{1'b1}}) begin
               retired <= retired + 1'b1;
            end
            if (halted_in) begin
               halt <= 1'b1;
            end else if (misaligned) begin
               // PC stays on the offending instruction for post-mortem.
               fault <= 1'b1;
               halt  <= 1'b1;
            end else begin
               pc <= next_pc;
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized run against a reference model.
// Runs a few thousand cycles.
// Memory and datapath responses are modelled with variable delays.
module tb_instr_fetch;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_b;
   logic             imem_req;
   logic [31:0]      imem_addr;
   logic             imem_ack;
   logic [31:0]      imem_rdata;
   logic [31:0]      inst;
   logic [5:0]       opcode;
   logic [5:0]       func;
   logic             inst_valid;
   logic             exec_done;
   logic             jump;
   logic             jump_reg;
   logic             branch;
   logic             zero;
   logic [31:0]      jr_target;
   logic             halted_in;
   logic [31:0]      pc;
   logic [31:0]      pc_plus4;
   logic             halt;
   logic             fault;
   logic [CNT_W-1:0] retired;

   int n_cmp = 0;
   int n_err = 0;

   instr_fetch #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_b(rst_b),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .inst(inst), .opcode(opcode), .func(func), .inst_valid(inst_valid),
      .exec_done(exec_done), .jump(jump), .jump_reg(jump_reg), .branch(branch), .zero(zero),
      .jr_target(jr_target), .halted_in(halted_in),
      .pc(pc), .pc_plus4(pc_plus4), .halt(halt), .fault(fault), .retired(retired)
   );

   always #5 clk = ~clk;

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] ins,
                                              input bit j, input bit jr, input bit br, input bit z,
                                              input logic [31:0] tgt);
      logic [31:0] seq;
      int          off;
      seq = p + 32'd4;
      if (j && jr) return tgt;
      if (j) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
      if (br && z) begin
         off = int'($signed(ins[15:0])) * 4;
         return seq + 32'(off);
      end
      return seq;
   endfunction

   function automatic logic [CNT_W-1:0] sat(input int n);
      return (n > 15) ? 4'hF : CNT_W'(n);
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic apply_reset();
      rst_b = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; exec_done = 1'b0;
      jump = 1'b0; jump_reg = 1'b0; branch = 1'b0; zero = 1'b0; halted_in = 1'b0; jr_target = 32'h0;
      repeat (3) @(negedge clk);
      rst_b = 1'b1;
   endtask

   // Waits for a request, answers it after 'delay' idle cycles, returns the requested address.
   task automatic fetch(input logic [31:0] data, input int delay, output logic [31:0] addr, output bit ok);
      ok = 1'b0;
      addr = 32'hxxxx_xxxx;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (imem_req === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) return;
      addr = imem_addr;
      repeat (delay) @(negedge clk);
      imem_ack = 1'b1;
      imem_rdata = data;
      @(negedge clk);
      imem_ack = 1'b0;
      exec_done = 1'b0;
      imem_rdata = $urandom;
   endtask

   task automatic execute(input bit j, input bit jr, input bit br, input bit z, input bit hi,
                          input logic [31:0] tgt);
      jump = j; jump_reg = jr; branch = br; zero = z; halted_in = hi; jr_target = tgt;
      exec_done = 1'b1;
      @(negedge clk);
      exec_done = 1'b0; jump = 1'b0; jump_reg = 1'b0; branch = 1'b0; zero = 1'b0; halted_in = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_b = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF; exec_done = 1'b1;
      jump = 1'b0; jump_reg = 1'b0; branch = 1'b0; zero = 1'b0; halted_in = 1'b0; jr_target = 32'h0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({imem_req, inst_valid, halt, fault} !== 4'b0000) begin
         n_err++; $display("FAIL reset_flags: got %b want 0000", {imem_req, inst_valid, halt, fault});
      end
      n_cmp++;
      if (pc !== 32'h0 || pc_plus4 !== 32'h4) begin
         n_err++; $display("FAIL reset_pc: got pc=%h pc_plus4=%h want 0/4", pc, pc_plus4);
      end
      n_cmp++;
      if (inst !== 32'h0 || retired !== 4'h0) begin
         n_err++; $display("FAIL reset_inst_ret: got inst=%h retired=%h want 0/0", inst, retired);
      end
      imem_ack = 1'b0; exec_done = 1'b0;
      rst_b = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         n_err++; $display("FAIL first_req: got req=%b addr=%h want 1/0", imem_req, imem_addr);
      end
   endtask

   task automatic test_add();
      logic [31:0] a;
      bit ok;
      apply_reset();
      fetch(32'h0000_0020, 2, a, ok);
      n_cmp++;
      if (!ok || a !== 32'h0) begin n_err++; $display("FAIL add_addr: got ok=%0d addr=%h want 0", ok, a); end
      n_cmp++;
      if (inst_valid !== 1'b1 || opcode !== 6'h00 || func !== 6'h20 || inst !== 32'h20) begin
         n_err++; $display("FAIL add_issue: got v=%b op=%h fn=%h inst=%h want 1/00/20/20", inst_valid, opcode, func, inst);
      end
      execute(0, 0, 0, 0, 0, 32'h0);
      n_cmp++;
      if (retired !== 4'h1 || inst_valid !== 1'b0 || imem_req !== 1'b0 || pc !== 32'h4) begin
         n_err++; $display("FAIL add_retire: got ret=%h v=%b req=%b pc=%h want 1/0/0/4", retired, inst_valid, imem_req, pc);
      end
      @(negedge clk);
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
         n_err++; $display("FAIL add_next_req: got req=%b addr=%h want 1/4", imem_req, imem_addr);
      end
   endtask

   task automatic test_branch();
      logic [31:0] a;
      bit ok;
      apply_reset();
      fetch(32'h0800_0004, 0, a, ok);          // J 0x10
      execute(1, 0, 0, 0, 0, 32'h0);
      fetch(32'h1000_FFFC, 1, a, ok);          // BEQ imm=-4
      n_cmp++;
      if (!ok || a !== 32'h10) begin n_err++; $display("FAIL beq_pc: got %h want 10", a); end
      execute(0, 0, 1, 1, 0, 32'h0);
      fetch(32'h0800_0004, 0, a, ok);
      n_cmp++;
      if (!ok || a !== 32'h4) begin n_err++; $display("FAIL beq_taken: got %h want 4", a); end
      execute(1, 0, 0, 0, 0, 32'h0);
      fetch(32'h1000_FFFC, 3, a, ok);
      execute(0, 0, 1, 0, 0, 32'h0);
      fetch(32'h0000_0020, 0, a, ok);
      n_cmp++;
      if (!ok || a !== 32'h14) begin n_err++; $display("FAIL beq_not_taken: got %h want 14", a); end
   endtask

   task automatic test_jump_fault();
      logic [31:0] a;
      bit ok;
      bit seen;
      apply_reset();
      fetch(32'h0000_0008, 0, a, ok);          // JR
      execute(1, 1, 0, 0, 0, 32'h1000_0008);
      fetch(32'h0800_0040, 0, a, ok);          // J idx=0x40
      n_cmp++;
      if (!ok || a !== 32'h1000_0008) begin n_err++; $display("FAIL jr_target: got %h want 10000008", a); end
      execute(1, 0, 0, 0, 0, 32'h0);
      fetch(32'h0000_0008, 0, a, ok);
      n_cmp++;
      if (!ok || a !== 32'h1000_0100) begin n_err++; $display("FAIL j_target: got %h want 10000100", a); end
      execute(1, 1, 0, 0, 0, 32'h0000_0203);
      n_cmp++;
      if (fault !== 1'b1 || halt !== 1'b1 || pc !== 32'h1000_0100 || retired !== 4'h3) begin
         n_err++; $display("FAIL fault_state: got f=%b h=%b pc=%h ret=%h want 1/1/10000100/3", fault, halt, pc, retired);
      end
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (imem_req !== 1'b0 || inst_valid !== 1'b0) seen = 1'b1;
      end
      n_cmp++;
      if (seen) begin n_err++; $display("FAIL fault_quiet: got activity=1 want 0"); end
   endtask

   task automatic test_halt();
      logic [31:0] a;
      bit ok;
      bit seen;
      apply_reset();
      fetch(32'h0800_0009, 0, a, ok);          // J 0x24
      execute(1, 0, 0, 0, 0, 32'h0);
      fetch(32'hFC00_0000, 2, a, ok);
      n_cmp++;
      if (!ok || a !== 32'h24) begin n_err++; $display("FAIL halt_pc_fetch: got %h want 24", a); end
      execute(0, 0, 0, 0, 1, 32'h0);
      n_cmp++;
      if (halt !== 1'b1 || fault !== 1'b0 || pc !== 32'h24 || retired !== 4'h2) begin
         n_err++; $display("FAIL halt_state: got h=%b f=%b pc=%h ret=%h want 1/0/24/2", halt, fault, pc, retired);
      end
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (imem_req !== 1'b0) seen = 1'b1;
      end
      n_cmp++;
      if (seen) begin n_err++; $display("FAIL halt_no_req: got req=1 want 0"); end
      execute(0, 0, 0, 0, 0, 32'h0);
      n_cmp++;
      if (retired !== 4'h2 || halt !== 1'b1 || pc !== 32'h24) begin
         n_err++; $display("FAIL halt_exec_ignored: got ret=%h h=%b pc=%h want 2/1/24", retired, halt, pc);
      end
   endtask

   task automatic test_reset_midfetch();
      logic [31:0] a;
      bit ok;
      apply_reset();
      fetch(32'h0800_0002, 0, a, ok);          // J 0x8
      execute(1, 0, 0, 0, 0, 32'h0);
      @(negedge clk);
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
         n_err++; $display("FAIL midfetch_req: got req=%b addr=%h want 1/8", imem_req, imem_addr);
      end
      #2 rst_b = 1'b0;
      #1;
      n_cmp++;
      if ({imem_req, inst_valid, halt, fault} !== 4'b0 || pc !== 32'h0 || inst !== 32'h0 || retired !== 4'h0) begin
         n_err++; $display("FAIL async_reset: got req=%b v=%b pc=%h inst=%h ret=%h want all 0", imem_req, inst_valid, pc, inst, retired);
      end
      @(negedge clk);
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      imem_ack = 1'b0;
      n_cmp++;
      if (inst !== 32'h0 || inst_valid !== 1'b0 || imem_req !== 1'b0) begin
         n_err++; $display("FAIL late_ack: got inst=%h v=%b req=%b want 0/0/0", inst, inst_valid, imem_req);
      end
      rst_b = 1'b1;
      fetch(32'h0000_0020, 0, a, ok);
      n_cmp++;
      if (!ok || a !== 32'h0 || inst !== 32'h20) begin
         n_err++; $display("FAIL restart: got addr=%h inst=%h want 0/20", a, inst);
      end
   endtask

   task automatic test_random();
      logic [31:0] a, ins, tgt, m_pc, np;
      int m_ret;
      bit ok, j, jr, br, z, hi;
      apply_reset();
      m_pc = 32'h0; m_ret = 0;
      for (int k = 0; k < 200; k++) begin
         ins = $urandom;
         exec_done = ($urandom_range(0, 1) == 1);   // ignored outside ISSUE
         fetch(ins, $urandom_range(0, 3), a, ok);
         n_cmp++;
         if (!ok || a !== m_pc) begin n_err++; $display("FAIL rnd_addr[%0d]: got %h want %h", k, a, m_pc); end
         n_cmp++;
         if (inst !== ins || opcode !== 6'(ins >> 26) || func !== 6'(ins & 32'h3F) || pc_plus4 !== m_pc + 32'd4) begin
            n_err++; $display("FAIL rnd_issue[%0d]: got inst=%h op=%h fn=%h pp4=%h want inst=%h", k, inst, opcode, func, pc_plus4, ins);
         end
         repeat ($urandom_range(0, 2)) begin        // stray acks while not requesting
            imem_ack = 1'b1; imem_rdata = $urandom;
            @(negedge clk);
            imem_ack = 1'b0;
         end
         n_cmp++;
         if (inst !== ins || inst_valid !== 1'b1) begin
            n_err++; $display("FAIL rnd_stray_ack[%0d]: got inst=%h v=%b want %h/1", k, inst, inst_valid, ins);
         end
         j  = ($urandom_range(0, 9) < 3);
         jr = j && ($urandom_range(0, 1) == 1);
         br = ($urandom_range(0, 1) == 1);
         z  = ($urandom_range(0, 1) == 1);
         hi = ($urandom_range(0, 19) == 0);
         tgt = $urandom;
         if ($urandom_range(0, 9) != 0) tgt = tgt & 32'hFFFF_FFFC;
         execute(j, jr, br, z, hi, tgt);
         m_ret++;
         np = model_next(m_pc, ins, j, jr, br, z, tgt);
         n_cmp++;
         if (retired !== sat(m_ret)) begin n_err++; $display("FAIL rnd_retired[%0d]: got %h want %h", k, retired, sat(m_ret)); end
         if (hi || (np % 4) != 0) begin
            n_cmp++;
            if (halt !== 1'b1 || fault !== (!hi) || pc !== m_pc) begin
               n_err++; $display("FAIL rnd_stop[%0d]: got h=%b f=%b pc=%h want 1/%b/%h", k, halt, fault, pc, !hi, m_pc);
            end
            apply_reset();
            m_pc = 32'h0; m_ret = 0;
         end else begin
            m_pc = np;
            n_cmp++;
            if (halt !== 1'b0 || fault !== 1'b0 || pc !== m_pc) begin
               n_err++; $display("FAIL rnd_step[%0d]: got h=%b f=%b pc=%h want 0/0/%h", k, halt, fault, pc, m_pc);
            end
         end
      end
   endtask

   task automatic test_saturate();
      logic [31:0] a;
      bit ok;
      apply_reset();
      for (int k = 1; k <= 17; k++) begin
         fetch(32'h0000_0020, 0, a, ok);
         n_cmp++;
         if (!ok || a !== 32'(4 * (k - 1))) begin n_err++; $display("FAIL sat_addr[%0d]: got %h want %h", k, a, 4 * (k - 1)); end
         execute(0, 0, 0, 0, 0, 32'h0);
         n_cmp++;
         if (retired !== sat(k)) begin n_err++; $display("FAIL sat_retired[%0d]: got %h want %h", k, retired, sat(k)); end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_branch();
      test_jump_fault();
      test_halt();
      test_reset_midfetch();
      test_random();
      test_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
